// File: rtl/cnn_dense_engine_pkg.sv
// rtl/cnn_dense_engine_pkg.sv - shared widths, FSM encoding and int8 saturation for the dense engine
package cnn_dense_engine_pkg;

  localparam int ACT_W         = 8;
  localparam int WGT_W         = 8;
  localparam int ACC_W_DEFAULT = 24;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_BIAS = 3'd1,
    S_MAC  = 3'd2,
    S_TAIL = 3'd3,
    S_POST = 3'd4,
    S_OUT  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  // Clamp a sign-extended requantised value into the int8 range.
  function automatic logic signed [ACT_W-1:0] sat8(input logic signed [31:0] v);
    if (v > 127) return 8'sh7f;
    if (v < -128) return 8'sh80;
    return v[ACT_W-1:0];
  endfunction

endpackage

// File: rtl/cnn_dense_engine_if.sv
// rtl/cnn_dense_engine_if.sv - weight/bias read ports and result stream of the dense engine
interface cnn_dense_engine_if
  import cnn_dense_engine_pkg::*;
#(
  parameter int N_IN  = 16,
  parameter int N_OUT = 8
);
  localparam int WA_W = $clog2(N_IN * N_OUT);
  localparam int OA_W = $clog2(N_OUT);

  logic        [WA_W-1:0]  w_addr;
  logic signed [WGT_W-1:0] w_data;
  logic        [OA_W-1:0]  b_addr;
  logic signed [WGT_W-1:0] b_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACT_W-1:0] out_data;
  logic        [OA_W-1:0]  out_idx;

  modport master (
    output w_addr, b_addr, out_valid, out_data, out_idx,
    input  w_data, b_data, out_ready
  );

  modport slave (
    input  w_addr, b_addr, out_valid, out_data, out_idx,
    output w_data, b_data, out_ready
  );

endinterface

// File: rtl/cnn_dense_engine_requant.sv
// rtl/cnn_dense_engine_requant.sv - accumulator to int8: arithmetic shift, saturate, ReLU under DENSE_RELU_EN
module cnn_dense_engine_requant
  import cnn_dense_engine_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int SHIFT = 7
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [ACT_W-1:0] q
);

  logic signed [ACC_W-1:0] shifted;
  logic signed [ACT_W-1:0] sat;

  always_comb begin
    shifted = acc >>> SHIFT;
    sat     = sat8(32'(shifted));
`ifdef DENSE_RELU_EN
    q = sat[ACT_W-1] ? '0 : sat;
`else
    q = sat;
`endif
  end

endmodule

// File: rtl/cnn_dense_engine.sv
// rtl/cnn_dense_engine.sv - sequential int8 dense-layer MAC engine, one streamed result per neuron
// Optional ReLU on results is selected with DENSE_RELU_EN (see cnn_dense_engine_requant).
module cnn_dense_engine
  import cnn_dense_engine_pkg::*;
#(
  parameter int N_IN  = 16,
  parameter int N_OUT = 8,
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int SHIFT = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      act_wr_en,
  input  logic [$clog2(N_IN)-1:0]   act_wr_addr,
  input  logic signed [ACT_W-1:0]   act_wr_data,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  cnn_dense_engine_if.master        bus
);

  localparam int IA_W = $clog2(N_IN);
  localparam int OA_W = $clog2(N_OUT);
  localparam int WA_W = $clog2(N_IN * N_OUT);
  localparam int P_W  = ACT_W + WGT_W;
  localparam logic [IA_W-1:0] K_LAST = IA_W'(N_IN - 1);
  localparam logic [OA_W-1:0] O_LAST = OA_W'(N_OUT - 1);

  state_t                  state, state_n;
  logic [IA_W-1:0]         k;
  logic [OA_W-1:0]         o;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACT_W-1:0] act_mem [N_IN];
  logic [IA_W-1:0]         act_idx;
  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACT_W-1:0] rq;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n       = state;
    busy          = 1'b0;
    done          = 1'b0;
    bus.out_valid = 1'b0;
    bus.b_addr    = '0;
    bus.w_addr    = '0;
    case (state)
      S_IDLE: begin
        if (start) state_n = S_BIAS;
      end
      S_BIAS: begin
        busy       = 1'b1;
        bus.b_addr = o;
        state_n    = S_MAC;
      end
      S_MAC: begin
        busy       = 1'b1;
        bus.w_addr = WA_W'(o) * WA_W'(N_IN) + WA_W'(k);
        if (k == K_LAST) state_n = S_TAIL;
      end
      S_TAIL: begin
        busy    = 1'b1;
        state_n = S_POST;
      end
      S_POST: begin
        busy    = 1'b1;
        state_n = S_OUT;
      end
      S_OUT: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_n = (o == O_LAST) ? S_DONE : S_BIAS;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // w_data lags w_addr by one cycle, so each MAC cycle consumes the activation one behind k.
  always_comb begin
    act_idx  = (state == S_TAIL) ? K_LAST : k - IA_W'(1);
    prod     = P_W'(act_mem[act_idx]) * P_W'(bus.w_data);
    prod_ext = ACC_W'(prod);
    bias_ext = ACC_W'(bus.b_data) <<< SHIFT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k            <= '0;
      o            <= '0;
      acc          <= '0;
      bus.out_data <= '0;
      bus.out_idx  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          k <= '0;
          if (start) o <= '0;
        end
        S_BIAS: k <= '0;
        S_MAC: begin
          k   <= k + IA_W'(1);
          acc <= (k == '0) ? bias_ext : acc + prod_ext;
        end
        S_TAIL: acc <= acc + prod_ext;
        S_POST: begin
          bus.out_data <= rq;
          bus.out_idx  <= o;
        end
        S_OUT: begin
          if (bus.out_ready && o != O_LAST) o <= o + OA_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Activation buffer survives reset; writes land only while idle.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && act_wr_en) act_mem[act_wr_addr] <= act_wr_data;
  end

  cnn_dense_engine_requant #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_requant (
    .acc (acc),
    .q   (rq)
  );

endmodule

// File: tb/tb_cnn_dense_engine.sv
// tb/tb_cnn_dense_engine.sv - directed self-checking bench for cnn_dense_engine with a 1-cycle ROM model
module tb_cnn_dense_engine;

  logic              clk = 1'b0;
  logic              rst;
  logic              act_wr_en;
  logic [3:0]        act_wr_addr;
  logic signed [7:0] act_wr_data;
  logic              start;
  logic              busy;
  logic              done;

  cnn_dense_engine_if #(.N_IN(16), .N_OUT(8)) bus ();

  cnn_dense_engine dut (
    .clk         (clk),
    .rst         (rst),
    .act_wr_en   (act_wr_en),
    .act_wr_addr (act_wr_addr),
    .act_wr_data (act_wr_data),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  logic signed [7:0] wrom [128];
  logic signed [7:0] brom [8];
  logic signed [7:0] tb_act [16];

  always @(posedge clk) begin
    bus.w_data <= wrom[bus.w_addr];
    bus.b_data <= brom[bus.b_addr];
  end

  int n_assert = 0;
  int n_fail   = 0;

  int exp_res [8];
  logic signed [7:0] res_d [8];
  logic [2:0]        res_i [8];
  int n_res, done_cnt, done_cyc;
  bit stable_ok;

  function automatic int relu_exp(input int v);
`ifdef DENSE_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] req);
    n_assert++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, req);
    end
  endtask

  // Fill ROMs and activations for a directed pattern and set the hand-derived expected results.
  task automatic load(input int mode);
    for (int o = 0; o < 8; o++) begin
      for (int i = 0; i < 16; i++) begin
        case (mode)
          1: begin tb_act[i] = 64;  wrom[o*16+i] = 2;    end
          2: begin tb_act[i] = 127; wrom[o*16+i] = 127;  end
          3: begin tb_act[i] = 100; wrom[o*16+i] = -100; end
          4: begin tb_act[i] = 16;  wrom[o*16+i] = 8'(4*o - 14); end
          5: begin tb_act[i] = 1;   wrom[o*16+i] = (o % 2 == 1) ? -8'sd1 : 8'sd1; end
          default: begin tb_act[i] = 8'(8*i); wrom[o*16+i] = (i == 15 - 2*o) ? 8'sd16 : 8'sd0; end
        endcase
      end
      case (mode)
        1: begin brom[o] = 10;  exp_res[o] = 26; end
        2: begin brom[o] = 127; exp_res[o] = 127; end
        3: begin brom[o] = 0;   exp_res[o] = relu_exp(-128); end
        4: begin brom[o] = 8'(3*o); exp_res[o] = relu_exp(11*o - 28); end
        5: begin brom[o] = 0;   exp_res[o] = relu_exp((o % 2 == 1) ? -1 : 0); end
        default: begin brom[o] = 0; exp_res[o] = 15 - 2*o; end
      endcase
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      act_wr_en = 1'b1; act_wr_addr = 4'(i); act_wr_data = tb_act[i];
    end
    @(negedge clk);
    act_wr_en = 1'b0;
  endtask

  // One layer pass; cyc counts cycles after the start edge, done is expected at cyc 161 (+stall).
  task automatic run_pass(input int stall_n, input int stall_len, input bit inject);
    int cyc;
    int stall_ctr = 0;
    logic signed [7:0] held_d = '0;
    logic [2:0]        held_i = '0;
    n_res = 0; done_cnt = 0; done_cyc = -1; stable_ok = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 1;
    while (cyc < 400) begin
      if (inject && cyc == 50) begin
        start = 1'b1; act_wr_en = 1'b1; act_wr_addr = 4'd0; act_wr_data = -8'sd5;
      end else if (inject && cyc == 51) begin
        start = 1'b0; act_wr_en = 1'b0;
      end
      bus.out_ready = 1'b1;
      if (bus.out_valid) begin
        if (int'(bus.out_idx) == stall_n && stall_ctr < stall_len) begin
          if (stall_ctr == 0) begin held_d = bus.out_data; held_i = bus.out_idx; end
          else if (bus.out_data !== held_d || bus.out_idx !== held_i) stable_ok = 1'b0;
          bus.out_ready = 1'b0;
          stall_ctr++;
        end else begin
          if (stall_ctr > 0 && int'(bus.out_idx) == stall_n && bus.out_data !== held_d) stable_ok = 1'b0;
          if (n_res < 8) begin res_d[n_res] = bus.out_data; res_i[n_res] = bus.out_idx; end
          n_res++;
        end
      end else if (stall_ctr > 0 && stall_ctr < stall_len) begin
        stable_ok = 1'b0;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      @(negedge clk); cyc++;
      if (done_cyc >= 0 && cyc > done_cyc + 4) break;
    end
  endtask

  task automatic check_pass(input string tag);
    chk({tag, "_nres"}, n_res, 8);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("%s_data%0d", tag, j), res_d[j], exp_res[j]);
      chk($sformatf("%s_idx%0d", tag, j), 32'(res_i[j]), j);
    end
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_busy_after"}, 32'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; act_wr_en = 1'b0; act_wr_addr = '0; act_wr_data = '0; start = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 128; i++) wrom[i] = '0;
    for (int i = 0; i < 8; i++) brom[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_idx", 32'(bus.out_idx), 0);
    chk("rst_waddr", 32'(bus.w_addr), 0);
    chk("rst_baddr", 32'(bus.b_addr), 0);
    rst = 1'b0;

    load(1); run_pass(-1, 0, 1'b0); check_pass("t1");
    chk("t1_done_cyc", done_cyc, 161);

    load(2); run_pass(-1, 0, 1'b0); check_pass("t2_sat_hi");
    load(3); run_pass(-1, 0, 1'b0); check_pass("t3_sat_lo");

    load(1); run_pass(3, 5, 1'b0); check_pass("t4_stall");
    chk("t4_done_cyc", done_cyc, 166);
    chk("t4_stable", 32'(stable_ok), 1);

    load(4); run_pass(-1, 0, 1'b0); check_pass("t_ramp");
    load(5); run_pass(-1, 0, 1'b0); check_pass("t_floor");
    load(6); run_pass(-1, 0, 1'b0); check_pass("t_onehot");

    // Abort in the MAC phase of neuron 2 (cycles 42..57 after start).
    load(1);
    done_cnt = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c < 45; c++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_valid", 32'(bus.out_valid), 0);
    chk("t5_done", 32'(done), 0);
    chk("t5_data", bus.out_data, 0);
    chk("t5_no_done_before", done_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    run_pass(-1, 0, 1'b0); check_pass("t5_restart");
    chk("t5_done_cyc", done_cyc, 161);

    run_pass(-1, 0, 1'b1); check_pass("t6_ignore");
    chk("t6_done_cyc", done_cyc, 161);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
